bpsk_tx_symbol_gen: RTL and testbench

Transmit-side source for the basic BPSK link. The block generates a PRBS9 bit stream and maps each bit to a signed ±A symbol. It zero-stuffs by the oversampling factor and flags the symbol-phase sample with a sync strobe. It feeds the transmit pulse-shaping filter and is the counterpart of the receive slicer. Its mapping is chosen so the slicer's sign decision recovers `o_bit` exactly.

---
 rtl/bpsk_tx_pkg.sv | 16 +
 rtl/prbs9_gen.sv | 30 +++
 rtl/bpsk_tx_symbol_gen.sv | 69 ++++++
 tb/tb_bpsk_tx_symbol_gen.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/bpsk_tx_pkg.sv
// Shared constants for the BPSK transmit source: PRBS9 geometry, default seed
// and the symbol amplitude helper.
package bpsk_tx_pkg;

    localparam int PRBS_LEN = 9;
    localparam int TAP_HI   = 8;
    localparam int TAP_LO   = 4;

    localparam logic [PRBS_LEN-1:0] DEFAULT_SEED = 9'h1FF;

    // Largest symmetric two's-complement magnitude, so +A and -A are both representable.
    function automatic int amplitude(input int s_out);
        return (1 << (s_out - 1)) - 1;
    endfunction

endpackage

// File: rtl/prbs9_gen.sv
// PRBS9 (x^9+x^5+1) generator; advances one step per strobe and
// recovers from the all-zero lock-up state by reloading the seed.
module prbs9_gen
    import bpsk_tx_pkg::*;
#(
    parameter logic [PRBS_LEN-1:0] SEED = DEFAULT_SEED
) (
    input  logic clock,
    input  logic i_reset,
    input  logic advance,
    output logic prbs_bit
);

    logic [PRBS_LEN-1:0] r;

    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            r <= SEED;
        end else if (advance) begin
            if (r == '0) begin
                r <= SEED;
            end else begin
                r <= {r[PRBS_LEN-2:0], r[TAP_HI] ^ r[TAP_LO]};
            end
        end
    end

    assign prbs_bit = r[TAP_HI];

endmodule

// File: rtl/bpsk_tx_symbol_gen.sv
// BPSK transmit source: PRBS9 bits mapped to +/-A, zero-stuffed by OS,
// with a sync strobe on the symbol-phase sample. Outputs are registered.
module bpsk_tx_symbol_gen
    import bpsk_tx_pkg::*;
#(
    parameter int                  OS        = 4,
    parameter int                  S_OUT     = 8,
    parameter logic [PRBS_LEN-1:0] PRBS_SEED = DEFAULT_SEED
) (
    input  logic                    clock,
    input  logic                    i_reset,
    input  logic                    i_enable,
    input  logic                    i_valid,
    output logic signed [S_OUT-1:0] o_symbol,
    output logic                    o_valid,
    output logic                    o_sync,
    output logic                    o_bit
);

    localparam int PW      = (OS > 2) ? $clog2(OS) : 1;
    localparam int A_INT   = amplitude(S_OUT);
    localparam int NEG_INT = -A_INT;

    localparam logic signed [S_OUT-1:0] SYM_POS    = A_INT[S_OUT-1:0];
    localparam logic signed [S_OUT-1:0] SYM_NEG    = NEG_INT[S_OUT-1:0];
    localparam logic [PW-1:0]           PHASE_LAST = PW'(OS - 1);

    logic [PW-1:0] phase;
    logic          accept;
    logic          at_symbol;
    logic          prbs_bit;

    assign accept    = i_enable & i_valid;
    assign at_symbol = accept && (phase == '0);

    prbs9_gen #(
        .SEED(PRBS_SEED)
    ) u_prbs (
        .clock    (clock),
        .i_reset  (i_reset),
        .advance  (at_symbol),
        .prbs_bit (prbs_bit)
    );

    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            phase    <= '0;
            o_symbol <= '0;
            o_valid  <= 1'b0;
            o_sync   <= 1'b0;
            o_bit    <= 1'b0;
        end else begin
            o_valid <= accept;
            if (accept) begin
                phase <= (phase == PHASE_LAST) ? '0 : phase + 1'b1;
                // Bit 1 maps to the non-negative level so a sign slicer recovers o_bit.
                if (phase == '0) begin
                    o_bit    <= prbs_bit;
                    o_symbol <= prbs_bit ? SYM_POS : SYM_NEG;
                    o_sync   <= 1'b1;
                end else begin
                    o_symbol <= '0;
                    o_sync   <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_bpsk_tx_symbol_gen.sv
// Scoreboard bench: driver pushes expected samples from a PRBS recurrence model,
// a negedge monitor pops and compares whenever the DUT presents o_valid.
module tb_bpsk_tx_symbol_gen;

    localparam int OS    = 4;
    localparam int S_OUT = 8;
    localparam logic [8:0] SEED = 9'h1FF;
    localparam int AMP   = 127;

    typedef struct {
        int sym;
        int sync;
        int bitv;
        int due;
    } exp_t;

    logic                    clock = 1'b0;
    logic                    i_reset;
    logic                    i_enable;
    logic                    i_valid;
    logic signed [S_OUT-1:0] o_symbol;
    logic                    o_valid;
    logic                    o_sync;
    logic                    o_bit;

    bpsk_tx_symbol_gen #(
        .OS        (OS),
        .S_OUT     (S_OUT),
        .PRBS_SEED (SEED)
    ) dut (
        .clock    (clock),
        .i_reset  (i_reset),
        .i_enable (i_enable),
        .i_valid  (i_valid),
        .o_symbol (o_symbol),
        .o_valid  (o_valid),
        .o_sync   (o_sync),
        .o_bit    (o_bit)
    );

    always #5 clock = ~clock;

    int   cycle = 0;
    always @(posedge clock) cycle <= cycle + 1;

    int   n_chk  = 0;
    int   n_fail = 0;
    bit   gold [0:4095];
    exp_t q [$];
    int   m_ticks, m_sym, m_bit;
    int   last_sym, last_sync, last_bit;
    int   sync_bits [$];
    int   sync_syms [$];
    int   slice_errs = 0;
    int   slice_n    = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ticks   = 0;
        m_sym     = 0;
        m_bit     = 0;
        last_sym  = 0;
        last_sync = 0;
        last_bit  = 0;
        q.delete();
    endtask

    // One cycle of stimulus; accepted ticks get their expected sample queued.
    task automatic tick(input bit v, input bit e);
        exp_t x;
        @(posedge clock);
        #1;
        i_valid  = v;
        i_enable = e;
        if (v && e) begin
            if (m_ticks % OS == 0) begin
                m_bit  = gold[m_sym];
                m_sym++;
                x.sym  = m_bit ? AMP : -AMP;
                x.sync = 1;
            end else begin
                x.sym  = 0;
                x.sync = 0;
            end
            x.bitv = m_bit;
            x.due  = cycle + 1;
            m_ticks++;
            q.push_back(x);
        end
    endtask

    initial begin : monitor
        exp_t e;
        bit   exp_v;
        forever begin
            @(negedge clock);
            if (i_reset === 1'b1) begin
                exp_v = (q.size() > 0) && (q[0].due <= cycle);
                chk("o_valid", int'(o_valid), int'(exp_v));
                if (o_valid && exp_v) begin
                    e = q.pop_front();
                    chk("o_symbol", int'(o_symbol), e.sym);
                    chk("o_sync", int'(o_sync), e.sync);
                    chk("o_bit", int'(o_bit), e.bitv);
                    last_sym  = e.sym;
                    last_sync = e.sync;
                    last_bit  = e.bitv;
                    if (o_sync) begin
                        sync_bits.push_back(int'(o_bit));
                        sync_syms.push_back(int'(o_symbol));
                        slice_n++;
                        if ((o_symbol >= 0) != o_bit) slice_errs++;
                    end
                end else if (!o_valid) begin
                    chk("hold_symbol", int'(o_symbol), last_sym);
                    chk("hold_sync", int'(o_sync), last_sync);
                    chk("hold_bit", int'(o_bit), last_bit);
                end
            end
        end
    end

    initial begin : main
        int ok;
        for (int k = 0; k < 9; k++) gold[k] = SEED[8-k];
        for (int k = 9; k < 4096; k++) gold[k] = gold[k-9] ^ gold[k-5];

        model_reset();
        i_reset  = 1'b0;
        i_enable = 1'b0;
        i_valid  = 1'b0;
        #3;
        chk("reset_symbol", int'(o_symbol), 0);
        chk("reset_valid", int'(o_valid), 0);
        chk("reset_sync", int'(o_sync), 0);
        chk("reset_bit", int'(o_bit), 0);
        @(posedge clock);
        #1;
        i_reset = 1'b1;

        // Full rate: covers seed run, PRBS period and 2000+ slicer symbols.
        for (int k = 0; k < 2050 * OS; k++) tick(1'b1, 1'b1);
        for (int k = 0; k < 3; k++) tick(1'b0, 1'b1);

        for (int k = 0; k < 9; k++) chk("seed_bit", sync_bits[k], 1);
        chk("seed_sym0", sync_syms[0], AMP);
        chk("tenth_bit", sync_bits[9], 0);
        chk("tenth_sym", sync_syms[9], -AMP);
        ok = 1;
        for (int k = 0; k + 511 < sync_bits.size(); k++)
            if (sync_bits[k] != sync_bits[k+511]) ok = 0;
        chk("prbs_period_511", ok, 1);
        ok = 0;
        for (int k = 1; k < 511; k++)
            if (sync_bits[k] != sync_bits[k+1] || sync_bits[0] != sync_bits[k]) ok = 1;
        chk("prbs_not_constant", ok, 1);
        chk("slicer_symbols_2000", int'(slice_n >= 2000), 1);
        chk("slicer_errors", slice_errs, 0);

        // Sparse ticks: one sample every third cycle, holds in between.
        for (int k = 0; k < 30; k++) begin
            tick(1'b1, 1'b1);
            tick(1'b0, 1'b1);
            tick(1'b0, 1'b1);
        end

        // Enable dropped for 5 ticks mid-symbol.
        while (m_ticks % OS != 2) tick(1'b1, 1'b1);
        for (int k = 0; k < 5; k++) tick(1'b1, 1'b0);
        for (int k = 0; k < 12; k++) tick(1'b1, 1'b1);

        for (int k = 0; k < 300; k++)
            tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0));

        // Reset with the phase-2 sample on the outputs.
        while (m_ticks % OS != 3) tick(1'b1, 1'b1);
        tick(1'b0, 1'b1);
        @(negedge clock);
        #1;
        i_reset = 1'b0;
        model_reset();
        #1;
        chk("midrst_symbol", int'(o_symbol), 0);
        chk("midrst_valid", int'(o_valid), 0);
        chk("midrst_sync", int'(o_sync), 0);
        chk("midrst_bit", int'(o_bit), 0);
        @(posedge clock);
        #1;
        i_reset = 1'b1;
        begin
            int base;
            base = sync_syms.size();
            for (int k = 0; k < 4 * OS; k++) tick(1'b1, 1'b1);
            for (int k = 0; k < 4; k++) tick(1'b0, 1'b1);
            chk("post_rst_first_sym", sync_syms[base], AMP);
            chk("post_rst_first_bit", sync_bits[base], int'(SEED[8]));
        end

        chk("scoreboard_drained", q.size(), 0);
        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
